// File: rtl/if_fetch_pkg.sv
// Shared fetch-stage definitions: widths, PC step, FSM encodings and the IF/ID payload.
package if_fetch_pkg;

    localparam int unsigned INSTR_W = 16;
    localparam int unsigned ADDR_W  = 16;
    localparam logic [ADDR_W-1:0] PC_INC = ADDR_W'(2);

    typedef enum logic [1:0] {
        S_BUSY  = 2'd0,
        S_HOLD  = 2'd1,
        S_DRAIN = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } fetch_word_t;

    // Instructions are halfword aligned, so redirect targets drop bit 0.
    function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] a);
        return {a[ADDR_W-1:1], 1'b0};
    endfunction

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: flush beats load, load beats hold, otherwise a bubble.
module ifid_reg
    import if_fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic        i_flush,
    input  logic        i_hold,
    input  fetch_word_t i_word,
    output fetch_word_t o_word,
    output logic        o_valid
);

    fetch_word_t r_word;
    logic        r_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_word  <= '0;
            r_valid <= 1'b0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_word  <= i_word;
            r_valid <= 1'b1;
        end else if (!i_hold) begin
            r_valid <= 1'b0;
        end
    end

    assign o_word  = r_word;
    assign o_valid = r_valid;

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch stage: one outstanding imem request, stall buffering and branch redirect.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               br_taken,
    input  logic [ADDR_W-1:0]  br_target,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] ifid_instr,
    output logic [ADDR_W-1:0]  ifid_pc,
    output logic               ifid_valid
);

    fetch_state_e      r_state;
    fetch_state_e      w_next_state;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_req_addr;
    fetch_word_t       r_buf;

    logic [ADDR_W-1:0] w_pc_next;
    logic [ADDR_W-1:0] w_req_next;
    logic              w_req;
    logic              w_load;
    logic              w_flush;
    logic              w_buf_load;
    fetch_word_t       w_word;
    fetch_word_t       w_fetched;
    fetch_word_t       w_ifid;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_BUSY;
        else     r_state <= w_next_state;
    end

    // A redirect always wins; a redirect with no ack must wait out the stale request.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_BUSY: begin
                if (br_taken)              w_next_state = imem_ack ? S_BUSY : S_DRAIN;
                else if (imem_ack && stall) w_next_state = S_HOLD;
            end
            S_HOLD: begin
                if (br_taken || !stall) w_next_state = S_BUSY;
            end
            S_DRAIN: begin
                if (!br_taken && imem_ack) w_next_state = S_BUSY;
            end
            default: w_next_state = S_BUSY;
        endcase
    end

    assign w_fetched = '{instr: imem_rdata, pc: r_req_addr};

    always_comb begin
        w_req      = (r_state != S_HOLD);
        w_pc_next  = r_pc;
        w_load     = 1'b0;
        w_flush    = 1'b0;
        w_buf_load = 1'b0;
        w_word     = w_fetched;
        if (br_taken) begin
            w_flush   = 1'b1;
            w_pc_next = align_pc(br_target);
        end else begin
            case (r_state)
                S_BUSY: begin
                    if (imem_ack && !stall) begin
                        w_load    = 1'b1;
                        w_pc_next = r_pc + PC_INC;
                    end else if (imem_ack) begin
                        w_buf_load = 1'b1;
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        w_load    = 1'b1;
                        w_word    = r_buf;
                        w_pc_next = r_pc + PC_INC;
                    end
                end
                default: ;
            endcase
        end
        // The request address only moves when a fresh fetch begins.
        w_req_next = (w_next_state == S_BUSY) ? w_pc_next : r_req_addr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc       <= RESET_PC;
            r_req_addr <= RESET_PC;
            r_buf      <= '0;
        end else begin
            r_pc       <= w_pc_next;
            r_req_addr <= w_req_next;
            if (w_buf_load) r_buf <= w_fetched;
        end
    end

    ifid_reg u_ifid_reg (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_flush (w_flush),
        .i_hold  (stall),
        .i_word  (w_word),
        .o_word  (w_ifid),
        .o_valid (ifid_valid)
    );

    assign imem_req   = w_req & ~rst;
    assign imem_addr  = r_req_addr;
    assign ifid_instr = w_ifid.instr;
    assign ifid_pc    = w_ifid.pc;

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch with a transaction-level fetch model and per-cycle compare.
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        br_taken;
    logic [15:0] br_target;
    logic        ack_en;

    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic [15:0] ifid_instr;
    logic [15:0] ifid_pc;
    logic        ifid_valid;

    logic        imem_req0;
    logic [15:0] imem_addr0;
    logic [15:0] ifid_instr0;
    logic [15:0] ifid_pc0;
    logic        ifid_valid0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return (a == 16'h0006) ? 16'hA5A5 : a;
    endfunction

    assign imem_ack   = ack_en;
    assign imem_rdata = mem_word(imem_addr);

    if_fetch #(.RESET_PC(16'hFFFE)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .ifid_instr (ifid_instr),
        .ifid_pc    (ifid_pc),
        .ifid_valid (ifid_valid)
    );

    // Default-parameter instance on a free-running zero-wait memory.
    if_fetch u_dut0 (
        .clk        (clk),
        .rst        (rst),
        .stall      (1'b0),
        .br_taken   (1'b0),
        .br_target  (16'h0000),
        .imem_req   (imem_req0),
        .imem_addr  (imem_addr0),
        .imem_ack   (imem_req0),
        .imem_rdata (imem_addr0),
        .ifid_instr (ifid_instr0),
        .ifid_pc    (ifid_pc0),
        .ifid_valid (ifid_valid0)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: next fetch address, an optional stale in-flight address, a held word, and IF/ID.
    logic [15:0] m_pc;
    logic [15:0] m_stale_addr;
    bit          m_stale;
    logic [31:0] m_buf[$];
    logic [15:0] m_instr;
    logic [15:0] m_ifpc;
    bit          m_valid;
    bit          m_live = 1'b0;

    function automatic bit m_req_f();
        return !rst && (m_buf.size() == 0);
    endfunction

    function automatic logic [15:0] m_addr_f();
        return m_stale ? m_stale_addr : m_pc;
    endfunction

    always @(posedge clk) begin : model
        bit ack_m;
        ack_m = m_req_f() && ack_en;
        if (rst) begin
            m_pc    = 16'hFFFE;
            m_stale = 1'b0;
            m_buf.delete();
            m_instr = 16'h0000;
            m_ifpc  = 16'h0000;
            m_valid = 1'b0;
            m_live  = 1'b1;
        end else if (br_taken) begin
            if (m_buf.size() != 0) begin
                m_buf.delete();
            end else if (!m_stale && !ack_m) begin
                m_stale      = 1'b1;
                m_stale_addr = m_pc;
            end
            m_pc    = br_target & 16'hFFFE;
            m_valid = 1'b0;
        end else if (m_buf.size() != 0) begin
            if (!stall) begin
                {m_instr, m_ifpc} = m_buf.pop_front();
                m_valid = 1'b1;
                m_pc    = m_pc + 16'd2;
            end
        end else if (m_stale) begin
            if (ack_m) m_stale = 1'b0;
            if (!stall) m_valid = 1'b0;
        end else if (ack_m && !stall) begin
            m_instr = mem_word(m_pc);
            m_ifpc  = m_pc;
            m_valid = 1'b1;
            m_pc    = m_pc + 16'd2;
        end else if (ack_m) begin
            m_buf.push_back({mem_word(m_pc), m_pc});
        end else if (!stall) begin
            m_valid = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("imem_req", 16'(imem_req), 16'(m_req_f()));
            if (m_req_f()) chk("imem_addr", imem_addr, m_addr_f());
            chk("ifid_valid", 16'(ifid_valid), 16'(m_valid));
            if (m_valid) begin
                chk("ifid_instr", ifid_instr, m_instr);
                chk("ifid_pc", ifid_pc, m_ifpc);
            end
        end
    end

    task automatic cyc(input bit s, input bit b, input logic [15:0] t, input bit a);
        stall     = s;
        br_taken  = b;
        br_target = t;
        ack_en    = a;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        cyc(0, 0, 16'h0000, 1);
        cyc(0, 0, 16'h0000, 1);
        chk("rst_valid", 16'(ifid_valid), 16'h0000);
        chk("rst_instr", ifid_instr, 16'h0000);
        chk("rst_pc", ifid_pc, 16'h0000);
        chk("rst_req", 16'(imem_req), 16'h0000);
        rst = 1'b0;
        #1;
        chk("first_req", 16'(imem_req), 16'h0001);
        chk("first_addr", imem_addr, 16'hFFFE);

        // Zero-wait streaming across the FFFE -> 0000 wrap.
        cyc(0, 0, 16'h0000, 1);
        chk("wrap_pc0", ifid_pc, 16'hFFFE);
        chk("wrap_addr", imem_addr, 16'h0000);
        chk("d0_pc0", ifid_pc0, 16'h0000);
        chk("d0_instr0", ifid_instr0, 16'h0000);
        cyc(0, 0, 16'h0000, 1);
        chk("d0_pc1", ifid_pc0, 16'h0002);
        cyc(0, 0, 16'h0000, 1);
        chk("d0_pc2", ifid_pc0, 16'h0004);
        chk("d0_valid", 16'(ifid_valid0), 16'h0001);
        cyc(0, 0, 16'h0000, 1);
        chk("seq_pc", ifid_pc, 16'h0004);
        chk("seq_addr", imem_addr, 16'h0006);

        // Stall three cycles while 0x0006 returns A5A5.
        cyc(1, 0, 16'h0000, 1);
        chk("stall_req", 16'(imem_req), 16'h0000);
        chk("stall_hold_pc", ifid_pc, 16'h0004);
        cyc(1, 0, 16'h0000, 1);
        cyc(1, 0, 16'h0000, 1);
        cyc(0, 0, 16'h0000, 1);
        chk("rel_instr", ifid_instr, 16'hA5A5);
        chk("rel_pc", ifid_pc, 16'h0006);
        chk("rel_addr", imem_addr, 16'h0008);

        // Ack held off four cycles with a redirect in the second.
        cyc(0, 0, 16'h0000, 0);
        cyc(0, 1, 16'h0041, 0);
        chk("drain_addr", imem_addr, 16'h0008);
        chk("drain_valid", 16'(ifid_valid), 16'h0000);
        cyc(0, 0, 16'h0000, 0);
        cyc(0, 0, 16'h0000, 0);
        cyc(0, 0, 16'h0000, 1);
        chk("redir_addr", imem_addr, 16'h0040);
        chk("redir_valid", 16'(ifid_valid), 16'h0000);
        cyc(0, 0, 16'h0000, 1);
        chk("redir_pc", ifid_pc, 16'h0040);

        // Redirect while holding a buffered word under stall.
        cyc(1, 0, 16'h0000, 1);
        cyc(1, 1, 16'h0100, 1);
        chk("hold_br_addr", imem_addr, 16'h0100);
        chk("hold_br_valid", 16'(ifid_valid), 16'h0000);
        cyc(0, 0, 16'h0000, 1);
        chk("hold_br_pc", ifid_pc, 16'h0100);

        // Redirect with ack in BUSY, then redirects while draining.
        cyc(0, 1, 16'h0200, 1);
        cyc(0, 1, 16'h0300, 0);
        cyc(0, 1, 16'h0401, 0);
        chk("drain2_addr", imem_addr, 16'h0200);
        cyc(0, 0, 16'h0000, 1);
        chk("drain2_next", imem_addr, 16'h0400);
        cyc(0, 0, 16'h0000, 1);
        cyc(1, 0, 16'h0000, 0);
        chk("stall_noack_pc", ifid_pc, 16'h0400);
        cyc(0, 0, 16'h0000, 1);
        cyc(0, 1, 16'hFFFF, 1);
        chk("odd_tgt_addr", imem_addr, 16'hFFFE);
        cyc(0, 0, 16'h0000, 1);
        cyc(0, 0, 16'h0000, 1);

        // Reset in the middle of an outstanding request.
        rst = 1'b1;
        ack_en = 1'b0;
        #1;
        chk("midrst_req", 16'(imem_req), 16'h0000);
        cyc(1, 1, 16'h1234, 1);
        rst = 1'b0;
        #1;
        chk("midrst_valid", 16'(ifid_valid), 16'h0000);
        chk("midrst_addr", imem_addr, 16'hFFFE);

        for (int i = 0; i < 20; i++) begin
            cyc((i % 5) == 3, (i == 7) || (i == 14), 16'h0800 + 16'(i), (i % 3) != 1);
        end
        cyc(0, 0, 16'h0000, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
